// File: rtl/home_inventory_wb_master.sv
// home_inventory_wb_master
//   Wishbone B4 classic initiator for the home inventory bring-up harness.
//   It takes one register command on a valid/ready port, runs exactly one
//   single-beat bus cycle, and returns read data or an error on a
//   valid/ready response port. An ack timeout keeps the harness from hanging
//   when no responder answers.
//
//   Optional feature: define HOME_INV_WBM_ERR_EN to add wbm_err_i. When the
//   macro is defined, an err without ack terminates the cycle like a timeout.
//
// Ports
//   wb_clk_i, wb_rst_ni           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_we/adr/dat/sel            command fields (1 = write)
//   rsp_valid/rsp_ready           response handshake
//   rsp_dat/rsp_err               read data (0 for writes/aborts), abort flag
//   wbm_cyc_o/stb_o/we_o/sel_o/adr_o/dat_o   Wishbone initiator outputs
//   wbm_ack_i/wbm_dat_i           Wishbone responder inputs
//   wbm_err_i                     responder error (HOME_INV_WBM_ERR_EN only)
//   busy                          high while a command is in flight
module home_inventory_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i,
`ifdef HOME_INV_WBM_ERR_EN
  input  logic        wbm_err_i,
`endif
  output logic        busy
);

  // Counter only has to reach TIMEOUT_CYCLES-1; keep at least one bit.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       dat_q, dat_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_dat_q, rsp_dat_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Abort condition: ack always wins, so abort is only taken without ack.
  logic abort_hit;
`ifdef HOME_INV_WBM_ERR_EN
  assign abort_hit = !wbm_ack_i && ((cnt_q == CNT_LAST) || wbm_err_i);
`else
  assign abort_hit = !wbm_ack_i && (cnt_q == CNT_LAST);
`endif

  // State and datapath registers. The asynchronous reset drops cyc/stb
  // immediately and discards any pending response.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= S_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (cmd_valid) state_d = S_REQ;
      S_REQ:   if (wbm_ack_i || abort_hit) state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered-output next values.
  always_comb begin
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          we_d  = cmd_we;
          sel_d = cmd_sel;
          adr_d = cmd_adr;
          dat_d = cmd_dat;
          cyc_d = 1'b1;
          cnt_d = '0;
        end
      end
      S_REQ: begin
        // cyc/stb drop on the edge that samples the termination, so the
        // responder never sees a second request.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? 32'h0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (abort_hit) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: begin
        cyc_d       = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Outputs: handshake/busy decode the state; everything else is a flop.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q == S_REQ) || (state_q == S_RESP);
    wbm_cyc_o = cyc_q;
    wbm_stb_o = cyc_q;
    wbm_we_o  = we_q;
    wbm_sel_o = sel_q;
    wbm_adr_o = adr_q;
    wbm_dat_o = dat_q;
    rsp_valid = rsp_valid_q;
    rsp_dat   = rsp_dat_q;
    rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_home_inventory_wb_master.sv
// Directed testbench for home_inventory_wb_master (TIMEOUT_CYCLES = 16).
// Inputs are driven and outputs sampled 1 ns after the rising edge.
module tb_home_inventory_wb_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
`ifdef HOME_INV_WBM_ERR_EN
  logic        wbm_err_i;
`endif
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  home_inventory_wb_master #(.TIMEOUT_CYCLES(16)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
`ifdef HOME_INV_WBM_ERR_EN
    .wbm_err_i (wbm_err_i),
`endif
    .busy      (busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present one command for exactly the accepting edge (DUT must be IDLE).
  task automatic send_cmd(input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rsp_handshake;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({cmd_ready, busy, wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 100000",
               {cmd_ready, busy, wbm_cyc_o, wbm_stb_o, rsp_valid, rsp_err});
    end
    checks++;
    if ({rsp_dat, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got rsp_dat=%h adr=%h dat=%h sel=%h we=%b expected all 0",
               rsp_dat, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    $display("reset: done");
  endtask

  task automatic test_write;
    int cyc_cnt = 0;
    wbm_dat_i = 32'hDEADBEEF;
    send_cmd(1'b1, 32'h104, 32'h5, 4'hF);
    if (wbm_cyc_o) cyc_cnt++;
    checks++;
    if ({wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {1'b1, 32'h104, 32'h5, 4'hF}) begin
      errors++;
      $display("FAIL write_bus: got we=%b adr=%h dat=%h sel=%h expected 1 00000104 00000005 f",
               wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
    end
    checks++;
    if ({wbm_stb_o, cmd_ready, busy} !== 3'b101) begin
      errors++;
      $display("FAIL write_req_state: got stb/ready/busy=%b expected 101",
               {wbm_stb_o, cmd_ready, busy});
    end
    tick();
    if (wbm_cyc_o) cyc_cnt++;
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    if (wbm_cyc_o) cyc_cnt++;
    checks++;
    if (cyc_cnt !== 2) begin
      errors++;
      $display("FAIL write_cyc_len: got %0d cycles expected 2", cyc_cnt);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL write_rsp: got valid=%b err=%b dat=%h expected 1 0 00000000",
               rsp_valid, rsp_err, rsp_dat);
    end
    rsp_handshake();
    checks++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL write_done: got valid/ready/busy=%b expected 010",
               {rsp_valid, cmd_ready, busy});
    end
    $display("write adr=00000104 dat=00000005: rsp_err=%b", rsp_err);
  endtask

  task automatic test_read;
    wbm_dat_i = 32'h48494348;
    send_cmd(1'b0, 32'h0, 32'h0, 4'hF);
    checks++;
    if ({cmd_ready, wbm_we_o, wbm_cyc_o} !== 3'b001) begin
      errors++;
      $display("FAIL read_accept: got ready/we/cyc=%b expected 001",
               {cmd_ready, wbm_we_o, wbm_cyc_o});
    end
    tick();
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat, wbm_cyc_o} !== {1'b1, 1'b0, 32'h48494348, 1'b0}) begin
      errors++;
      $display("FAIL read_rsp: got valid=%b err=%b dat=%h cyc=%b expected 1 0 48494348 0",
               rsp_valid, rsp_err, rsp_dat, wbm_cyc_o);
    end
    tick();
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b01) begin
      errors++;
      $display("FAIL read_hold: got ready/valid=%b expected 01", {cmd_ready, rsp_valid});
    end
    rsp_handshake();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL read_done: got cmd_ready=%b expected 1", cmd_ready);
    end
    $display("read adr=00000000: rsp_dat=%h", rsp_dat);
  endtask

  task automatic test_timeout;
    int n = 0;
    wbm_dat_i = 32'h12345678;
    send_cmd(1'b0, 32'h200, 32'h0, 4'hF);
    while (wbm_cyc_o && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL timeout_len: got %0d cycles expected 16", n);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat, wbm_stb_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      errors++;
      $display("FAIL timeout_rsp: got valid=%b err=%b dat=%h stb=%b expected 1 1 00000000 0",
               rsp_valid, rsp_err, rsp_dat, wbm_stb_o);
    end
    rsp_handshake();
    $display("timeout adr=00000200: rsp_err=%b after %0d cycles", rsp_err, n);

    // Ack on the 16th cycle completes normally.
    send_cmd(1'b0, 32'h204, 32'h0, 4'hF);
    repeat (15) tick();
    checks++;
    if (wbm_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge_cyc: got cyc=%b expected 1", wbm_cyc_o);
    end
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat, wbm_cyc_o} !== {1'b1, 1'b0, 32'h12345678, 1'b0}) begin
      errors++;
      $display("FAIL timeout_edge_ack: got valid=%b err=%b dat=%h cyc=%b expected 1 0 12345678 0",
               rsp_valid, rsp_err, rsp_dat, wbm_cyc_o);
    end
    rsp_handshake();
    $display("late-ack adr=00000204: rsp_err=%b", rsp_err);
  endtask

  task automatic test_backpressure;
    wbm_dat_i = 32'hA5A50001;
    send_cmd(1'b0, 32'h008, 32'h0, 4'hF);
    tick();
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 32'h0;
    cmd_we = 1'b1; cmd_adr = 32'h00C; cmd_dat = 32'h7; cmd_sel = 4'h3;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({rsp_valid, rsp_dat, cmd_ready, wbm_cyc_o} !== {1'b1, 32'hA5A50001, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got valid=%b dat=%h ready=%b cyc=%b expected 1 a5a50001 0 0",
                 i, rsp_valid, rsp_dat, cmd_ready, wbm_cyc_o);
      end
    end
    rsp_handshake();
    checks++;
    if ({rsp_valid, cmd_ready, wbm_cyc_o} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release: got valid/ready/cyc=%b expected 010",
               {rsp_valid, cmd_ready, wbm_cyc_o});
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_sel_o} !== {1'b1, 1'b1, 32'h00C, 4'h3}) begin
      errors++;
      $display("FAIL bp_next_cmd: got cyc=%b we=%b adr=%h sel=%h expected 1 1 0000000c 3",
               wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_sel_o);
    end
    tick();
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    rsp_handshake();
    $display("backpressure adr=00000008 then adr=0000000c: done");
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b1;
    cmd_we = 1'b1; cmd_adr = 32'h010; cmd_dat = 32'h1; cmd_sel = 4'hF;
    cmd_valid = 1'b1;
    tick();                    // edge N: accepted
    tick();
    wbm_ack_i = 1'b1;
    tick();                    // edge N+2: ack sampled
    wbm_ack_i = 1'b0;
    checks++;
    if ({rsp_valid, wbm_cyc_o} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_rsp: got valid/cyc=%b expected 10", {rsp_valid, wbm_cyc_o});
    end
    cmd_adr = 32'h014;
    tick();                    // edge N+3: response consumed
    checks++;
    if ({rsp_valid, cmd_ready, wbm_cyc_o} !== 3'b010) begin
      errors++;
      $display("FAIL b2b_idle: got valid/ready/cyc=%b expected 010",
               {rsp_valid, cmd_ready, wbm_cyc_o});
    end
    tick();                    // edge N+4: next command accepted
    cmd_valid = 1'b0;
    checks++;
    if ({wbm_cyc_o, wbm_adr_o} !== {1'b1, 32'h014}) begin
      errors++;
      $display("FAIL b2b_next: got cyc=%b adr=%h expected 1 00000014", wbm_cyc_o, wbm_adr_o);
    end
    tick();
    wbm_ack_i = 1'b1;
    tick();
    wbm_ack_i = 1'b0;
    tick();
    rsp_ready = 1'b0;
    $display("back-to-back adr=00000010/00000014: done");
  endtask

  task automatic test_reset_mid_req;
    send_cmd(1'b1, 32'h100, 32'h3, 4'hF);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, busy} !== 5'b00010) begin
      errors++;
      $display("FAIL async_reset: got cyc/stb/valid/ready/busy=%b expected 00010",
               {wbm_cyc_o, wbm_stb_o, rsp_valid, cmd_ready, busy});
    end
    wbm_ack_i = 1'b1;          // stray ack across reset release and in IDLE
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if ({wbm_cyc_o, rsp_valid, cmd_ready, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_release: got cyc/valid/ready/busy=%b expected 0010",
               {wbm_cyc_o, rsp_valid, cmd_ready, busy});
    end
    wbm_ack_i = 1'b0;
    $display("reset mid-REQ adr=00000100: cycle abandoned");
  endtask

`ifdef HOME_INV_WBM_ERR_EN
  task automatic test_err;
    wbm_dat_i = 32'h0BADF00D;
    send_cmd(1'b0, 32'h020, 32'h0, 4'hF);
    tick();
    wbm_err_i = 1'b1;
    tick();
    wbm_err_i = 1'b0;
    checks++;
    if ({wbm_cyc_o, rsp_valid, rsp_err, rsp_dat} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      errors++;
      $display("FAIL err_abort: got cyc=%b valid=%b err=%b dat=%h expected 0 1 1 00000000",
               wbm_cyc_o, rsp_valid, rsp_err, rsp_dat);
    end
    rsp_handshake();
    send_cmd(1'b0, 32'h024, 32'h0, 4'hF);
    tick();
    wbm_err_i = 1'b1;
    wbm_ack_i = 1'b1;
    tick();
    wbm_err_i = 1'b0;
    wbm_ack_i = 1'b0;
    checks++;
    if ({rsp_valid, rsp_err, rsp_dat} !== {1'b1, 1'b0, 32'h0BADF00D}) begin
      errors++;
      $display("FAIL err_ack_priority: got valid=%b err=%b dat=%h expected 1 0 0badf00d",
               rsp_valid, rsp_err, rsp_dat);
    end
    rsp_handshake();
    wbm_err_i = 1'b1;
    tick();
    wbm_err_i = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      errors++;
      $display("FAIL err_idle_ignored: got valid/ready=%b expected 01", {rsp_valid, cmd_ready});
    end
    $display("err termination adr=00000020/00000024: done");
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    rsp_ready = 1'b0;
    wbm_ack_i = 1'b0; wbm_dat_i = '0;
`ifdef HOME_INV_WBM_ERR_EN
    wbm_err_i = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_req();
`ifdef HOME_INV_WBM_ERR_EN
    test_err();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
